// File: rtl/seq_det_param.sv
// Mealy serial-pattern detector with a run-time loadable PAT_W-bit pattern,
// overlapping or non-overlapping detection, and a saturating match counter.
module seq_det_param #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             pat_load,
  input  logic             overlap,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_reg;
  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;

  logic [PAT_W-1:0]  window;
  logic              full;
  logic              bit_take;
  logic              hit;
  logic              cnt_sat;

  // Oldest held bit sits at the top so the window lines up with pat_reg directly.
  assign window   = {hist, x};
  assign full     = (fill == FILL_FULL);
  assign bit_take = rst && x_valid && !pat_load;
  assign hit      = bit_take && full && (window == pat_reg);
  assign y        = hit;
  assign cnt_sat  = &match_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_reg   <= '1;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else if (pat_load) begin
      pat_reg <= pat_in;
      fill    <= '0;
    end else if (x_valid) begin
      hist <= window[PAT_W-2:0];
      if (hit) begin
        // Non-overlapping: the whole match is consumed, so refill from scratch.
        if (!overlap)
          fill <= '0;
        if (!cnt_sat)
          match_cnt <= match_cnt + CNT_W'(1);
      end else if (!full) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule
